image_uart_tx: RTL and testbench
================================

Name: image_uart_tx

Overview:
- Reads a stored raw RGB image out of the picture BRAM read port and streams it over UART, 8N1.
- Sends each pixel as three bytes; the PC uses this to read back the frame that the receive path loaded.
- Runs in the 100 MHz base clock domain, next to the picture memory controller.
- Contains its own bit serializer and its own memory address sequencer.

Parameters:
- CLK_FREQ, 100000000: clock frequency in Hz.
- BAUD_RATE, 1000000: serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, must be ≥ 2.
- H_SIZE, 607: image width in pixels.
- V_SIZE, 455: image height in pixels.
- ADDR_W, 19: BRAM address width. H_SIZE*V_SIZE must be ≤ 2^ADDR_W.

Ports:
- clk, input, 1: base clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to dump the frame. Sampled only in IDLE.
- rd_en, output, 1: BRAM read enable, one-cycle pulse.
- rd_addr, output, ADDR_W: linear pixel address, row*H_SIZE+col.
- rd_data, input, 18: raw pixel {R[5:0],G[5:0],B[5:0]}. Valid exactly one cycle after rd_en.
- tx_serial, output, 1: UART line. Idles high.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse after the final stop bit of the last pixel.

Behaviour:
- Reset values: tx_serial=1, busy=0, done=0, rd_en=0, rd_addr=0. State is IDLE and all counters are 0.
- A reset mid-frame aborts the dump immediately. tx_serial returns high in the same edge; a truncated byte on the line is acceptable.
- States are IDLE, READ, WAIT, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE: if start=1 at edge k, set pix_addr=0, busy=1 and go to READ. start in any other state is ignored.
- READ (cycle k+1): rd_en=1, rd_addr=pix_addr. Go to WAIT.
- WAIT (cycle k+2): capture rd_data into the pixel register. Set byte_idx=0. Go to LOAD.
- LOAD (1 cycle): form shift byte = {chan[5:0],2'b00}, left-aligned. The channel is R for byte_idx 0, G for 1, B for 2. Go to START_BIT.
  - The first start-bit cycle on tx_serial is therefore k+4.
- START_BIT: tx_serial=0 for CLKS_PER_BIT cycles.
- DATA_BITS: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx_serial=1 for CLKS_PER_BIT cycles. Then:
  - If byte_idx<2: increment byte_idx and go to LOAD.
  - Otherwise go to NEXT.
- Byte spacing: one LOAD cycle of idle-high between bytes of the same pixel, so each byte takes 10*CLKS_PER_BIT+1 cycles. Between pixels there are 3 extra idle-high cycles (NEXT, READ, WAIT) before LOAD.
- NEXT:
  - If pix_addr==H_SIZE*V_SIZE-1: pulse done=1, set busy=0, return to IDLE. rd_addr holds its last value.
  - Otherwise increment pix_addr and go to READ.
- Bit timer: counts 0..CLKS_PER_BIT-1 and advances the bit/state on the terminal count. Width is clog2(CLKS_PER_BIT).
- rd_en is high only in READ, never more than one cycle per pixel. rd_addr is stable whenever rd_en=1.
- Total dump length = H_SIZE*V_SIZE*3 bytes. The default frame is 828555 bytes.
- done and start in the same cycle: done is a state output, so the start is seen in IDLE on the following cycle only if still asserted. A start pulse coincident with done is lost.
- No flow control. The line rate is fixed by BAUD_RATE.

Test Plan:
- Setup for all tests: CLK_FREQ=1000, BAUD_RATE=100 (10 clocks/bit), H_SIZE=4, V_SIZE=2, with a BRAM model returning addr-derived pixels.
- Reset check → tx_serial=1, busy=0, done=0, rd_en=0 throughout 50 idle cycles.
- start at cycle k, BRAM[0]=18'h3F_000 (R=63) → rd_en at k+1 with rd_addr=0, tx low at k+4. The decoded bytes are 0xFC, 0x00, 0x00, with a 1-cycle gap between bytes.
- Full dump of 8 pixels → 24 bytes decoded in address order 0..7, done pulses exactly once 1 cycle after the final stop bit, busy falls with it, and exactly 8 rd_en pulses are seen.
- start re-asserted while busy, at pixel 3 → no restart, addresses stay monotonic, still 24 bytes total.
- reset asserted mid-byte of pixel 5 → tx_serial=1 and busy=0 next cycle. A new start then dumps again from address 0.
- Back-to-back: start held high for one cycle after done → a second full 24-byte dump begins. Byte values are cross-checked against the B=6'h2A → 0xA8 encoding.

Source files
------------

// File: rtl/image_uart_tx.sv
// Streams the stored RGB frame out of the picture BRAM as 8N1 UART bytes,
// three bytes per pixel (R, G, B), each channel left-aligned in its byte.
module image_uart_tx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 1000000,
  parameter int H_SIZE    = 607,
  parameter int V_SIZE    = 455,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [17:0]       rd_data,
  output logic              tx_serial,
  output logic              busy,
  output logic              done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_SIZE * V_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_START_BIT, S_DATA_BITS, S_STOP_BIT, S_NEXT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [17:0]         pixel_q, pixel_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
  logic                tx_q, tx_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_tick;

  assign bit_tick = (baud_cnt_q == BIT_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pix_addr_d = pix_addr_q;
    pixel_d    = pixel_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pix_addr_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        pixel_d    = rd_data;
        byte_idx_d = 2'd0;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        unique case (byte_idx_q)
          2'd0:    shift_d = {pixel_q[17:12], 2'b00};
          2'd1:    shift_d = {pixel_q[11:6],  2'b00};
          default: shift_d = {pixel_q[5:0],   2'b00};
        endcase
        state_d = S_START_BIT;
      end
      S_START_BIT: begin
        baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
        if (bit_tick) begin
          bit_idx_d = 3'd0;
          state_d   = S_DATA_BITS;
        end
      end
      S_DATA_BITS: begin
        baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
        if (bit_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP_BIT;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_STOP_BIT: begin
        baud_cnt_d = bit_tick ? '0 : baud_cnt_q + 1'b1;
        if (bit_tick) begin
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_LOAD;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (pix_addr_q == PIX_LAST) begin
          state_d = S_IDLE;
        end else begin
          pix_addr_d = pix_addr_q + 1'b1;
          state_d    = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it glitch-free.
    rd_en_d   = (state_d == S_READ);
    rd_addr_d = (state_d == S_READ) ? pix_addr_d : rd_addr_q;
    done_d    = (state_d == S_NEXT) && (pix_addr_q == PIX_LAST);
    busy_d    = (state_d != S_IDLE) && !done_d;
    if (state_d == S_START_BIT)      tx_d = 1'b0;
    else if (state_d == S_DATA_BITS) tx_d = shift_d[0];
    else                             tx_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pix_addr_q <= '0;
      pixel_q    <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_addr_q <= pix_addr_d;
      pixel_q    <= pixel_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_serial = tx_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_image_uart_tx.sv
// Self-checking bench for image_uart_tx: random 4x2 frames, a UART line decoder
// and an arithmetic timing/byte model of the dump.
module tb_image_uart_tx;

  localparam int CPB    = 10;
  localparam int NPIX   = 8;
  localparam int NBYTE  = 3 * NPIX;
  localparam int BYTE_T = 10 * CPB + 1;
  localparam int PIX_T  = 3 * BYTE_T + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [18:0] rd_addr;
  logic [17:0] rd_data = '0;
  logic        tx_serial;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  image_uart_tx #(
    .CLK_FREQ (1000),
    .BAUD_RATE(100),
    .H_SIZE   (4),
    .V_SIZE   (2),
    .ADDR_W   (19)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx_serial(tx_serial),
    .busy     (busy),
    .done     (done)
  );

  logic [17:0] mem [NPIX];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[2:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: cycle counter, rd_en/done logs and a mid-bit UART decoder.
  int          cyc = 0;
  bit          dec_on = 0;
  int          dec_cnt = 0;
  int          dec_start = 0;
  logic [7:0]  dec_byte = '0;
  logic [7:0]  byte_q[$];
  int          bstart_q[$];
  bit          stop_q[$];
  int          rd_addr_log[$];
  int          rd_cyc_log[$];
  int          done_cyc_log[$];
  bit          done_busy_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      rd_addr_log.push_back(int'(rd_addr));
      rd_cyc_log.push_back(cyc);
    end
    if (done) begin
      done_cyc_log.push_back(cyc);
      done_busy_log.push_back(busy);
    end
    if (reset) begin
      dec_on = 0;
    end else if (dec_on) begin
      dec_cnt++;
      if (dec_cnt % CPB == CPB / 2) begin
        if ((dec_cnt / CPB) inside {[1:8]}) begin
          dec_byte[dec_cnt / CPB - 1] = tx_serial;
        end else if (dec_cnt / CPB == 9) begin
          byte_q.push_back(dec_byte);
          bstart_q.push_back(dec_start);
          stop_q.push_back(tx_serial);
          dec_on = 0;
        end
      end
    end else if (tx_serial === 1'b0) begin
      dec_on    = 1;
      dec_cnt   = 0;
      dec_start = cyc;
    end
  end

  task automatic clear_logs();
    byte_q.delete(); bstart_q.delete(); stop_q.delete();
    rd_addr_log.delete(); rd_cyc_log.delete();
    done_cyc_log.delete(); done_busy_log.delete();
  endtask

  function automatic logic [7:0] exp_byte(input int j);
    logic [17:0] p;
    p = mem[j / 3];
    case (j % 3)
      0:       return {p[17:12], 2'b00};
      1:       return {p[11:6],  2'b00};
      default: return {p[5:0],   2'b00};
    endcase
  endfunction

  task automatic randomize_mem();
    for (int a = 0; a < NPIX; a++) mem[a] = 18'($urandom);
    mem[0]      = 18'h3F000;
    mem[2][5:0] = 6'h2A;
  endtask

  task automatic goto_cycle(input int t);
    while (cyc + 1 < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Called in the drive phase; returns in the drive phase of cycle ks+2.
  task automatic launch(output int ks);
    clear_logs();
    start = 1'b1;
    ks = cyc + 1;
    @(negedge clk); check("busy_before_accept", busy, 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); check("busy_after_accept", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_results(input int ks);
    check("byte_count", byte_q.size(), NBYTE);
    for (int j = 0; j < byte_q.size() && j < NBYTE; j++) begin
      check($sformatf("byte%0d_val", j), byte_q[j], exp_byte(j));
      check($sformatf("byte%0d_start", j), bstart_q[j], ks + 4 + (j / 3) * PIX_T + (j % 3) * BYTE_T);
      check($sformatf("byte%0d_stop", j), stop_q[j], 1);
    end
    check("rd_count", rd_addr_log.size(), NPIX);
    for (int a = 0; a < rd_addr_log.size() && a < NPIX; a++) begin
      check($sformatf("rd%0d_addr", a), rd_addr_log[a], a);
      check($sformatf("rd%0d_cycle", a), rd_cyc_log[a], ks + 1 + a * PIX_T);
    end
    if (done_cyc_log.size() > 0) begin
      check("done_cycle", done_cyc_log[0], ks + 4 + (NPIX - 1) * PIX_T + 3 * BYTE_T - 1);
      check("busy_at_done", done_busy_log[0], 0);
    end
  endtask

  // Waits for done; with chain=1 holds start through the done cycle and the one after.
  task automatic finish_dump(input int ks, input bit chain, output int ks2);
    int t;
    t = 0;
    ks2 = 0;
    while (done !== 1'b1 && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    check("done_seen", done, 1);
    if (chain) start = 1'b1;
    @(negedge clk); #1;
    check_results(ks);
    if (chain) begin
      @(posedge clk); #1;
      ks2 = cyc + 1;
      @(negedge clk); #1;
      check("coincident_start_lost", busy, 0);
      check("done_count", done_cyc_log.size(), 1);
      clear_logs();
      @(posedge clk); #1; start = 1'b0;
    end else begin
      repeat (20) begin @(posedge clk); #1; end
      check("done_count", done_cyc_log.size(), 1);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ks, ks2, dummy;
    randomize_mem();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_outputs", {tx_serial, busy, done, rd_en}, 4'b1000);
    end
    check("idle_rd_addr", rd_addr, 0);
    @(posedge clk); #1;

    // Single full dump; first pixel is pure red, pixel 2 blue is 6'h2A.
    launch(ks);
    finish_dump(ks, 0, dummy);
    if (byte_q.size() >= 9) begin
      check("px0_r", byte_q[0], 8'hFC);
      check("px0_g", byte_q[1], 8'h00);
      check("px0_b", byte_q[2], 8'h00);
      check("px2_b", byte_q[8], 8'hA8);
    end

    // start re-asserted during pixel 3 must be ignored.
    randomize_mem();
    launch(ks);
    goto_cycle(ks + 3 * PIX_T + 150);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    finish_dump(ks, 0, dummy);

    // Reset mid-byte of pixel 5, then a fresh dump from address 0.
    randomize_mem();
    launch(ks);
    goto_cycle(ks + 4 + 5 * PIX_T + 50);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk); #1;
    check("reset_tx", tx_serial, 1);
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_rd_count", rd_addr_log.size(), 6);
    check("reset_byte_count", byte_q.size(), 15);
    check("reset_no_done", done_cyc_log.size(), 0);
    @(posedge clk); #1;
    launch(ks);
    finish_dump(ks, 0, dummy);

    // Back-to-back: start held across done and the following idle cycle.
    randomize_mem();
    launch(ks);
    finish_dump(ks, 1, ks2);
    finish_dump(ks2, 0, dummy);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
